regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined core.
//  - NRD combinational read ports and NWR synchronous write ports.
//  - Entry 0 is hardwired to zero.
//  - Write-to-read bypass on every read port.
//  - Per-register busy scoreboard: set when decode claims rd, cleared on writeback.

---
 rtl/regfile_mp.sv | 110 +++++++++++
 tb/tb_regfile_mp.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: combinational reads with write bypass,
// synchronous writes (highest port wins), x0 hardwired to zero, per-register busy scoreboard.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  mem_rd [NREGS];
  logic [NREGS-1:0] busy_rd;

  genvar gi;

  // One storage slice per architectural register; x0 is a constant.
  for (gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign mem_rd[gi]  = '0;
      assign busy_rd[gi] = 1'b0;
    end else begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(gi);

      logic [XLEN-1:0] data_q;
      logic [XLEN-1:0] data_d;
      logic            busy_q;
      logic            busy_d;
      logic            wr_hit;
      logic            claim_hit;

      // Ascending scan so the highest-index matching port overrides the rest.
      always_comb begin
        wr_hit = 1'b0;
        data_d = data_q;
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == IDX)) begin
            wr_hit = 1'b1;
            data_d = wr_data[w*XLEN +: XLEN];
          end
        end
      end

      // A fresh claim outranks a writeback from the older producer.
      always_comb begin
        claim_hit = claim_en && (claim_addr == IDX);
        busy_d    = busy_q;
        if (claim_hit) begin
          busy_d = 1'b1;
        end else if (wr_hit) begin
          busy_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q <= '0;
          busy_q <= 1'b0;
        end else begin
          data_q <= data_d;
          busy_q <= busy_d;
        end
      end

      assign mem_rd[gi]  = data_q;
      assign busy_rd[gi] = busy_q;
    end
  end

  assign busy_vec = busy_rd;

  // Read ports: stored value, overridden by any same-cycle write to the same register.
  for (gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            byp;

    always_comb begin
      ra   = rd_addr[gi*AW +: AW];
      byp  = 1'b0;
      data = mem_rd[ra];
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
          byp  = 1'b1;
          data = wr_data[w*XLEN +: XLEN];
        end
      end
      // Reset blanks the bypass path too, so outputs read zero for its whole duration.
      if (reset || (ra == '0)) begin
        byp  = 1'b0;
        data = '0;
      end
    end

    assign rd_data[gi*XLEN +: XLEN] = data;
    assign rd_busy[gi]              = busy_rd[ra] && !byp && !reset;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, random traffic against a
// behavioural model, and asynchronous-reset corner sequences.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic [NREGS-1:0]    busy_vec;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec)
  );

  // Behavioural model: architectural state only.
  logic [XLEN-1:0] m_mem [NREGS];
  logic            m_busy [NREGS];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  ra0;
    logic [31:0] exp_d;
    logic        exp_b;
    logic [31:0] exp_bv;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(string n, logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic ce, logic [4:0] ca,
                              logic [4:0] ra0, logic [31:0] ed, logic eb, logic [31:0] ebv);
    vec_t v;
    v.name = n; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ce = ce; v.ca = ca; v.ra0 = ra0; v.exp_d = ed; v.exp_b = eb; v.exp_bv = ebv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
  endtask

  task automatic set_wr(input int w, input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en[w]              = en;
    wr_addr[w*AW +: AW]   = a;
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Reference read: x0 is zero, newest same-cycle write (highest port) forwards.
  function automatic logic [31:0] exp_data(input int r);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = rd_addr[r*AW +: AW];
    if (reset || a == 0) return '0;
    v = m_mem[a];
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_rbusy(input int r);
    logic [AW-1:0] a;
    logic          fwd;
    a   = rd_addr[r*AW +: AW];
    fwd = 1'b0;
    if (reset || a == 0) return 1'b0;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) fwd = 1'b1;
    return m_busy[a] && !fwd;
  endfunction

  function automatic logic [31:0] exp_bvec();
    logic [31:0] v;
    v = '0;
    if (!reset)
      for (int i = 1; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != 0)
          m_mem[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      for (int w = 0; w < NWR; w++)
        if (wr_en[w]) m_busy[wr_addr[w*AW +: AW]] = 1'b0;
      if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < NRD; r++) begin
      chk($sformatf("%s rd_data[%0d] a=%0d", tag, r, rd_addr[r*AW +: AW]),
          rd_data[r*XLEN +: XLEN], exp_data(r));
      chk($sformatf("%s rd_busy[%0d] a=%0d", tag, r, rd_addr[r*AW +: AW]),
          32'(rd_busy[r]), 32'(exp_rbusy(r)));
    end
    chk($sformatf("%s busy_vec", tag), busy_vec, exp_bvec());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    tbl[0]  = mk("wr5_bypass",   2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 0);
    tbl[1]  = mk("rd5_stored",   2'b00, 0, 0,            0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 0);
    tbl[2]  = mk("wr0_claim0",   2'b01, 0, 32'h12345678, 0, 0, 1, 0, 0, 32'h0,        0, 0);
    tbl[3]  = mk("rd0_after",    2'b00, 0, 0,            0, 0, 0, 0, 0, 32'h0,        0, 0);
    tbl[4]  = mk("conflict_x7",  2'b11, 7, 32'h1,        7, 32'h2, 0, 0, 7, 32'h2,    0, 0);
    tbl[5]  = mk("x7_stored2",   2'b00, 0, 0,            0, 0, 0, 0, 7, 32'h2,        0, 0);
    tbl[6]  = mk("dual_x7_x8",   2'b11, 7, 32'hAA,       8, 32'hBB, 0, 0, 8, 32'hBB,  0, 0);
    tbl[7]  = mk("x7_is_AA",     2'b00, 0, 0,            0, 0, 0, 0, 7, 32'hAA,       0, 0);
    tbl[8]  = mk("claim3",       2'b00, 0, 0,            0, 0, 1, 3, 3, 32'h0,        0, 0);
    tbl[9]  = mk("x3_busy",      2'b00, 0, 0,            0, 0, 0, 0, 3, 32'h0,        1, 32'h8);
    tbl[10] = mk("wb3_fwd",      2'b01, 3, 32'h9,        0, 0, 0, 0, 3, 32'h9,        0, 32'h8);
    tbl[11] = mk("x3_clear",     2'b00, 0, 0,            0, 0, 0, 0, 3, 32'h9,        0, 0);
    tbl[12] = mk("claim_wr3",    2'b01, 3, 32'hA,        0, 0, 1, 3, 3, 32'hA,        0, 0);
    tbl[13] = mk("x3_still_bsy", 2'b00, 0, 0,            0, 0, 0, 0, 3, 32'hA,        1, 32'h8);

    idle();
    rd_addr = '0;
    reset   = 1'b1;
    model_reset();
    #1;
    check_all("reset_init");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Directed vectors; the other read ports watch x7 and x3 for extra coverage.
    for (int i = 0; i < 14; i++) begin
      idle();
      set_wr(0, tbl[i].we[0], tbl[i].wa0, tbl[i].wd0);
      set_wr(1, tbl[i].we[1], tbl[i].wa1, tbl[i].wd1);
      claim_en   = tbl[i].ce;
      claim_addr = tbl[i].ca;
      rd_addr    = {5'd3, 5'd7, tbl[i].ra0};
      #1;
      chk({tbl[i].name, " rd0"},  rd_data[XLEN-1:0], tbl[i].exp_d);
      chk({tbl[i].name, " busy0"}, 32'(rd_busy[0]), 32'(tbl[i].exp_b));
      chk({tbl[i].name, " bvec"},  busy_vec, tbl[i].exp_bv);
      check_all(tbl[i].name);
      tick();
    end

    // Random traffic; small address window half the time to force conflicts and bypasses.
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int w = 0; w < NWR; w++)
        set_wr(w, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
               $urandom);
      claim_en   = ($urandom_range(0, 9) < 3);
      claim_addr = 5'($urandom_range(0, 7));
      for (int r = 0; r < NRD; r++)
        rd_addr[r*AW +: AW] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7))
                                                            : 5'($urandom_range(0, 31));
      #1;
      check_all($sformatf("rand%0d", c));
      tick();
    end

    // Async reset mid-cycle with x3 busy and a write to x4 pending.
    idle();
    claim_en   = 1'b1;
    claim_addr = 5'd3;
    set_wr(0, 1'b1, 5'd4, 32'h77);
    tick();
    idle();
    set_wr(1, 1'b1, 5'd4, 32'h55);
    rd_addr = {5'd9, 5'd3, 5'd4};
    #1;
    check_all("pre_reset");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst rd0", rd_data[XLEN-1:0], 32'h0);
    chk("async_rst bvec", busy_vec, 32'h0);
    check_all("async_rst");
    tick();
    check_all("rst_held");
    reset = 1'b0;
    idle();
    rd_addr = {5'd9, 5'd3, 5'd4};
    #1;
    chk("post_rst x4", rd_data[XLEN-1:0], 32'h0);
    check_all("post_rst");
    tick();
    set_wr(0, 1'b1, 5'd4, 32'hA5);
    #1;
    check_all("wr_x4_A5");
    tick();
    idle();
    rd_addr = {5'd0, 5'd4, 5'd4};
    #1;
    chk("x4_is_A5", rd_data[XLEN-1:0], 32'hA5);
    check_all("x4_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
